// File: rtl/key_debounce.sv
// rtl/key_debounce.sv - push-button synchroniser/debouncer with press/release strobes; optional auto-repeat under KEY_DEBOUNCE_REPEAT_EN
module key_debounce #(
  parameter int NUM_KEYS        = 2,
  parameter int CNT_WIDTH       = 16,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int ACTIVE_LOW      = 1,
  parameter int RPT_WIDTH       = 26,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [NUM_KEYS-1:0] key_raw,
  output logic [NUM_KEYS-1:0] key_clean,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_release
);

  // Pin level of a released key; the synchroniser powers up showing "released".
  localparam logic REL_LVL = (ACTIVE_LOW != 0);
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

  typedef enum logic {ST_STABLE = 1'b0, ST_COUNTING = 1'b1} state_t;

  logic [NUM_KEYS-1:0] r_sync1;
  logic [NUM_KEYS-1:0] r_sync2;

  // Two-flop synchroniser for the asynchronous pin levels.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1 <= {NUM_KEYS{REL_LVL}};
      r_sync2 <= {NUM_KEYS{REL_LVL}};
    end else begin
      r_sync1 <= key_raw;
      r_sync2 <= r_sync1;
    end
  end

`ifndef KEY_DEBOUNCE_REPEAT_EN
  // Repeat parameters have no hardware in this build.
  logic [31:0] w_unused_rpt;
  assign w_unused_rpt = RPT_WIDTH ^ REPEAT_DELAY ^ REPEAT_PERIOD;
`endif

  for (genvar g = 0; g < NUM_KEYS; g++) begin : g_key
    state_t               r_state;
    logic [CNT_WIDTH-1:0] r_cnt;
    logic                 r_clean;
    logic                 r_press;
    logic                 r_release;
    logic                 w_pressed;
    logic                 w_rpt_fire;

    assign w_pressed = r_sync2[g] ^ REL_LVL;

`ifdef KEY_DEBOUNCE_REPEAT_EN
    localparam logic [RPT_WIDTH-1:0] RPT_DELAY_LAST  = RPT_WIDTH'(REPEAT_DELAY - 1);
    localparam logic [RPT_WIDTH-1:0] RPT_PERIOD_LAST = RPT_WIDTH'(REPEAT_PERIOD - 1);

    logic [RPT_WIDTH-1:0] r_rpt_cnt;
    logic                 r_rpt_on;

    // First repeat waits the long delay; once repeating, the shorter period applies.
    assign w_rpt_fire = (r_state == ST_STABLE) && r_clean &&
                        (r_rpt_cnt == (r_rpt_on ? RPT_PERIOD_LAST : RPT_DELAY_LAST));

    // Repeat timer runs only while a key is held and settled; any disturbance restarts it.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        r_rpt_cnt <= '0;
        r_rpt_on  <= 1'b0;
      end else if ((r_state != ST_STABLE) || !r_clean) begin
        r_rpt_cnt <= '0;
        r_rpt_on  <= 1'b0;
      end else if (w_rpt_fire) begin
        r_rpt_cnt <= '0;
        r_rpt_on  <= 1'b1;
      end else begin
        r_rpt_cnt <= r_rpt_cnt + RPT_WIDTH'(1);
      end
    end
`else
    assign w_rpt_fire = 1'b0;
`endif

    // Per-key debounce FSM: a new level must be seen for DEBOUNCE_CYCLES+1 edges to commit.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        r_state   <= ST_STABLE;
        r_cnt     <= '0;
        r_clean   <= 1'b0;
        r_press   <= 1'b0;
        r_release <= 1'b0;
      end else begin
        r_press   <= w_rpt_fire;
        r_release <= 1'b0;
        case (r_state)
          ST_STABLE: begin
            if (w_pressed != r_clean) begin
              r_state <= ST_COUNTING;
              r_cnt   <= '0;
            end
          end
          ST_COUNTING: begin
            if (w_pressed == r_clean) begin
              r_state <= ST_STABLE;
              r_cnt   <= '0;
            end else if (r_cnt == CNT_LAST) begin
              r_state   <= ST_STABLE;
              r_cnt     <= '0;
              r_clean   <= w_pressed;
              r_press   <= w_pressed;
              r_release <= !w_pressed;
            end else begin
              r_cnt <= r_cnt + CNT_WIDTH'(1);
            end
          end
          default: begin
            r_state <= ST_STABLE;
            r_cnt   <= '0;
          end
        endcase
      end
    end

    assign key_clean[g]   = r_clean;
    assign key_press[g]   = r_press;
    assign key_release[g] = r_release;
  end

endmodule

// File: doc/key_debounce.md
# key_debounce

Debounces and synchronises the raw DE0-Nano push-button inputs before they reach the key PIO's `in_port`. Each key passes through a 2-flop synchroniser and a per-key stability counter. The block produces a clean, active-high "pressed" level per key, plus single-cycle press and release strobes. The PIO's edge capture therefore sees exactly one rising edge per physical press.

## Interface
- `NUM_KEYS`, default 2: number of independent keys.
- `CNT_WIDTH`, default 16: width of each debounce counter.
- `DEBOUNCE_CYCLES`, default 50000: cycles a new level must hold before it is accepted (1 ms at 50 MHz). Valid range is 1 .. 2^CNT_WIDTH-1.
- `ACTIVE_LOW`, default 1: 1 means a raw pin reads 0 when pressed.
- `RPT_WIDTH`, default 26: width of the auto-repeat counter. Used only with `KEY_DEBOUNCE_REPEAT_EN`.
- `REPEAT_DELAY`, default 25000000: cycles from the press strobe to the first repeat strobe.
- `REPEAT_PERIOD`, default 5000000: cycles between subsequent repeat strobes.

Ports:
- `clk`  in  1  system clock.
- `reset_n`  in  1  reset, asynchronous, active-low.
- `key_raw`  in  NUM_KEYS  asynchronous pin levels.
- `key_clean`  out  NUM_KEYS  debounced level, 1 = pressed; drives PIO `in_port`.
- `key_press`  out  NUM_KEYS  one-cycle strobe on an accepted press (and on each repeat, if enabled).
- `key_release`  out  NUM_KEYS  one-cycle strobe on an accepted release.

## Operation
Every key is handled independently with identical logic.

**Synchroniser**
- `key_raw` feeds sync1, which feeds sync2.
- Both flops reset to the released pin level (`ACTIVE_LOW` ? 1 : 0).

**Pressed level**
- p = sync2 XOR `ACTIVE_LOW`.

**State machine, two states**
- STABLE:
  - If p != `key_clean`, go to COUNTING and set cnt <= 0.
  - Otherwise hold.
- COUNTING:
  - If p == `key_clean` (a bounce back), go to STABLE and set cnt <= 0. Nothing is emitted.
  - Otherwise, if cnt == `DEBOUNCE_CYCLES`-1, commit and go to STABLE:
    - `key_clean` <= p.
    - Pulse `key_press` if p = 1, or `key_release` if p = 0.
  - Otherwise cnt <= cnt+1.

**Counter and outputs**
- The counter is unsigned, CNT_WIDTH bits, and never wraps: the compare bounds it.
- All outputs are registered. Strobes are 1 for exactly one cycle and 0 otherwise.

**Reset values**
- `key_clean`, `key_press` and `key_release` are all 0.
- State is STABLE and cnt = 0.
- The repeat counter is 0.

**Reset mid-operation**
- A reset during COUNTING aborts the count.
- No strobe is emitted.
- `key_clean` returns to 0 even if a key was held. If the key is still held after reset, it is re-accepted as a fresh press after the full latency.

**Simultaneous events**
- Keys commit independently. Several bits of `key_press`/`key_release` may be high in the same cycle.

## Timing
- **Latency:** a raw change first captured by sync1 at edge E0 reaches sync2 at E1. The FSM enters COUNTING at E2. `key_clean` and the strobe update at edge E2+`DEBOUNCE_CYCLES`.
  - Total latency is `DEBOUNCE_CYCLES`+2 cycles from the capturing edge.
- **Glitch rejection:**
  - A level held for fewer than `DEBOUNCE_CYCLES` cycles after synchronisation has no effect on the outputs.
  - Any return to the committed level restarts the full count.
- **Downstream timing:** the PIO edge detector (rising edge of `in_port`) registers the press 2 cycles after `key_clean` rises.

## Configuration
Macro `KEY_DEBOUNCE_REPEAT_EN` controls auto-repeat.

Defined:
- Each key has a RPT_WIDTH-bit repeat counter.
- The counter runs only while `key_clean` = 1 and the state is STABLE. It is cleared on the press commit and whenever `key_clean` = 0 or the state is COUNTING.
- Extra `key_press` strobes fire `REPEAT_DELAY` cycles after the press strobe, then every `REPEAT_PERIOD` cycles while the key is held.
- `key_clean` stays 1 throughout, so the PIO sees no additional edges. The repeats are visible on `key_press` only.

Undefined:
- No repeat logic is synthesised and the repeat parameters are ignored.
- `key_press` fires exactly once per accepted press.

## Test plan
Bench settings: `NUM_KEYS`=2, `DEBOUNCE_CYCLES`=8, `ACTIVE_LOW`=1.

1. **Clean press:** drive `key_raw`[0] 1→0 and hold for 20 cycles. Required: `key_clean`[0] rises 10 cycles after the capturing edge; `key_press`[0] is high for exactly 1 cycle in the same cycle; `key_release`=0.
2. **Bouncy press:** drive `key_raw`[0] 0 for 3 cycles, 1 for 2 cycles, 0 for 5, 1 for 1, then 0 held. Required: a single `key_press`[0] strobe, 10 cycles after the final 1→0 capture; `key_clean`[0] makes no intermediate transitions.
3. **Glitch:** pulse `key_raw`[1] low for 7 cycles while the key is released. Required: `key_clean`[1], `key_press`[1] and `key_release`[1] all stay 0.
4. **Reset mid-count:** assert `reset_n`=0 for 2 cycles, 5 cycles into a press count, with the key still held. Required: all outputs 0 during reset, no strobe, then `key_press`[0] fires 10 cycles after reset release.
5. **Simultaneous keys:** drive both `key_raw` bits 1→0 on the same edge, hold 20 cycles, then release both. Required: `key_press`=2'b11 for one cycle, then `key_release`=2'b11 for one cycle, 10 cycles after release.
6. **Auto-repeat (macro defined):** set `REPEAT_DELAY`=30 and `REPEAT_PERIOD`=10, and hold key 0 for 70 cycles after the press commit. Required: `key_press`[0] strobes at +0, +30, +40, +50 and +60 cycles; without the macro, only the +0 strobe.
